// File: rtl/pll_clk_manager.sv
// rtl/pll_clk_manager.sv - PLL lock supervisor, downstream reset and clock-enable generator
//
// Runs entirely in the PLL output clock domain. Qualifies the PLL lock,
// holds a downstream reset until lock has been stable, produces NUM_CH
// programmable clock-enable strobes and counts lock-loss events.
//
// Ports:
//   clock_in        PLL output clock, the only clock
//   reset_n         asynchronous active-low reset
//   pll_locked      raw PLL LOCK (asynchronous)
//   div_ratio       per-channel divide ratio, channel k at [k*DIV_W +: DIV_W]
//   div_load        one-cycle strobe: capture div_ratio
//   lock_loss_clear one-cycle strobe: clear lock_loss_count
//   rst_out_n       synchronous active-low reset for downstream logic
//   locked          qualified lock, high only in RUN
//   ce_out          per-channel clock-enable strobes
//   lock_loss_count saturating count of RUN->LOST transitions

module pll_clk_manager #(
    parameter int NUM_CH             = 2,
    parameter int DIV_W              = 16,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int SYNC_STAGES        = 2,
    parameter int CNT_W              = 8
) (
    input  logic                      clock_in,
    input  logic                      reset_n,
    input  logic                      pll_locked,
    input  logic [NUM_CH*DIV_W-1:0]   div_ratio,
    input  logic                      div_load,
    input  logic                      lock_loss_clear,
    output logic                      rst_out_n,
    output logic                      locked,
    output logic [NUM_CH-1:0]         ce_out,
    output logic [CNT_W-1:0]          lock_loss_count
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILISE = 2'd1,
        RUN       = 2'd2,
        LOST      = 2'd3
    } state_t;

    localparam int SW = $clog2(LOCK_STABLE_CYCLES);
    localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE_CYCLES - 1);

    state_t                 state;
    state_t                 next_state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lk_s;
    logic [SW-1:0]          stab_cnt;
    logic                   run_next;
    logic                   loss_event;

    assign lk_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    // State register plus the stable-lock counter that qualifies STABILISE.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state    <= WAIT_LOCK;
            stab_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == STABILISE) begin
                stab_cnt <= stab_cnt + 1'b1;
            end else begin
                stab_cnt <= '0;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            WAIT_LOCK: if (lk_s) next_state = STABILISE;
            STABILISE: begin
                if (!lk_s) begin
                    next_state = WAIT_LOCK;
                end else if (stab_cnt == STAB_LAST) begin
                    next_state = RUN;
                end
            end
            RUN:       if (!lk_s) next_state = LOST;
            default:   next_state = WAIT_LOCK;
        endcase
    end

    // Outputs are decoded from next_state so they change on the same edge
    // as the state itself.
    always_comb begin
        run_next   = (next_state == RUN);
        loss_event = (state == RUN) && (next_state == LOST);
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            rst_out_n <= 1'b0;
            locked    <= 1'b0;
        end else begin
            rst_out_n <= run_next;
            locked    <= run_next;
        end
    end

    // A clear coinciding with a loss leaves exactly that one loss counted.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            lock_loss_count <= '0;
        end else if (lock_loss_clear) begin
            lock_loss_count <= loss_event ? CNT_W'(1) : '0;
        end else if (loss_event && (lock_loss_count != {CNT_W{1'b1}})) begin
            lock_loss_count <= lock_loss_count + 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DIV_W-1:0] shadow;
        logic [DIV_W-1:0] pend;
        logic [DIV_W-1:0] cnt;
        logic             pend_v;
        logic             ce_q;
        logic [DIV_W-1:0] new_ratio;
        logic             fast;
        logic             wrap;

        assign new_ratio = div_ratio[k*DIV_W +: DIV_W];
        // Ratios 0 and 1 both mean "strobe every cycle".
        assign fast      = (shadow < DIV_W'(2));
        // A wrap is the only point where the ratio may change without
        // distorting the running period.
        assign wrap      = (state == RUN) && (fast || (cnt == shadow - DIV_W'(1)));
        assign ce_out[k] = ce_q;

        always_ff @(posedge clock_in or negedge reset_n) begin
            if (!reset_n) begin
                shadow <= '0;
                pend   <= '0;
                pend_v <= 1'b0;
                cnt    <= '0;
                ce_q   <= 1'b0;
            end else begin
                ce_q <= run_next && ((state == RUN) ? wrap : fast);

                if ((state != RUN) || wrap) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end

                if ((state != RUN) || wrap) begin
                    if (div_load) begin
                        shadow <= new_ratio;
                    end else if (pend_v) begin
                        shadow <= pend;
                    end
                    pend_v <= 1'b0;
                end else if (div_load) begin
                    pend   <= new_ratio;
                    pend_v <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pll_clk_manager.sv
// tb/tb_pll_clk_manager.sv - self-checking bench for pll_clk_manager

module tb_pll_clk_manager;

    localparam int NUM_CH = 2;
    localparam int DIV_W  = 16;
    localparam int LSC    = 16;
    localparam int SS     = 2;
    localparam int CNT_W  = 2;
    localparam int LAT    = SS + 1 + LSC;

    logic                    clock_in = 1'b0;
    logic                    reset_n;
    logic                    pll_locked;
    logic [NUM_CH*DIV_W-1:0] div_ratio;
    logic                    div_load;
    logic                    lock_loss_clear;
    logic                    rst_out_n;
    logic                    locked;
    logic [NUM_CH-1:0]       ce_out;
    logic [CNT_W-1:0]        lock_loss_count;

    int checks = 0;
    int errors = 0;

    pll_clk_manager #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_STABLE_CYCLES(LSC),
        .SYNC_STAGES(SS), .CNT_W(CNT_W)
    ) dut (
        .clock_in(clock_in), .reset_n(reset_n), .pll_locked(pll_locked),
        .div_ratio(div_ratio), .div_load(div_load), .lock_loss_clear(lock_loss_clear),
        .rst_out_n(rst_out_n), .locked(locked), .ce_out(ce_out),
        .lock_loss_count(lock_loss_count)
    );

    always #5 clock_in = ~clock_in;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    task automatic set_ratio(input int r0, input int r1);
        div_ratio[0*DIV_W +: DIV_W] = DIV_W'(r0);
        div_ratio[1*DIV_W +: DIV_W] = DIV_W'(r1);
    endtask

    task automatic hard_reset();
        step();
        reset_n = 1'b0; pll_locked = 1'b0; div_load = 1'b0; lock_loss_clear = 1'b0;
        #2;
        reset_n = 1'b1;
        step();
    endtask

    task automatic load_ratios(input int r0, input int r1);
        set_ratio(r0, r1);
        div_load = 1'b1;
        step();
        div_load = 1'b0;
    endtask

    // Raises pll_locked just after the current edge and returns the edge
    // index (1-based) at which locked is first seen high, or -1.
    task automatic bring_up(output int edges);
        bit done = 0;
        pll_locked = 1'b1;
        edges = -1;
        for (int i = 1; i <= 200; i++) begin
            if (!done) begin
                step();
                if (locked === 1'b1) begin
                    edges = i;
                    done = 1;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; pll_locked = 1'b0; div_load = 1'b0; lock_loss_clear = 1'b0;
        div_ratio = '0;
        #23;
        checks++;
        if ({rst_out_n, locked, ce_out, lock_loss_count} !== '0) begin
            errors++;
            $display("FAIL reset_state: got rst_out_n=%b locked=%b ce=%b cnt=%0d, want all 0",
                     rst_out_n, locked, ce_out, lock_loss_count);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_lock_latency();
        int e;
        hard_reset();
        bring_up(e);
        checks++;
        if (e !== LAT) begin
            errors++;
            $display("FAIL lock_latency: locked rose at edge %0d, want %0d", e, LAT);
        end
        checks++;
        if (rst_out_n !== 1'b1 || lock_loss_count !== '0) begin
            errors++;
            $display("FAIL lock_outputs: rst_out_n=%b cnt=%0d, want 1 and 0", rst_out_n, lock_loss_count);
        end
    endtask

    task automatic test_glitch();
        int first = -1;
        hard_reset();
        pll_locked = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (i == 10) pll_locked = 1'b0;
            if (i == 11) pll_locked = 1'b1;
            if (first < 0 && rst_out_n === 1'b1) first = i;
        end
        checks++;
        if (first !== 11 + LAT) begin
            errors++;
            $display("FAIL glitch_restart: rst_out_n rose at edge %0d, want %0d", first, 11 + LAT);
        end
        checks++;
        if (lock_loss_count !== '0) begin
            errors++;
            $display("FAIL glitch_count: got %0d, want 0", lock_loss_count);
        end
    endtask

    // Scenario 0: ratios 4/1; scenario 1: 4 reloaded with 6 at RUN cycle 5;
    // scenarios 2..5: random ratios and random reloads.
    task automatic test_dividers();
        int r_cur[NUM_CH], nxt[NUM_CH], pnd[NUM_CH], val[NUM_CH];
        bit pv[NUM_CH];
        bit [NUM_CH-1:0] exp_ce;
        int strobes[$];
        int e, n_cyc;
        bit ld;
        for (int sc = 0; sc < 6; sc++) begin
            hard_reset();
            if (sc == 0) begin r_cur[0] = 4; r_cur[1] = 1; n_cyc = 20; end
            else if (sc == 1) begin r_cur[0] = 4; r_cur[1] = 1; n_cyc = 22; end
            else begin
                r_cur[0] = $urandom_range(0, 9); r_cur[1] = $urandom_range(0, 9); n_cyc = 60;
            end
            load_ratios(r_cur[0], r_cur[1]);
            bring_up(e);
            checks++;
            if (e !== LAT) begin
                errors++;
                $display("FAIL div_bringup sc%0d: locked at edge %0d, want %0d", sc, e, LAT);
            end
            for (int k = 0; k < NUM_CH; k++) begin
                exp_ce[k] = (r_cur[k] <= 1);
                nxt[k] = r_cur[k];
                pv[k] = 0;
            end
            checks++;
            if (ce_out !== exp_ce) begin
                errors++;
                $display("FAIL div_entry sc%0d: ce=%b want %b", sc, ce_out, exp_ce);
            end
            strobes.delete();
            for (int t = 1; t <= n_cyc; t++) begin
                ld = 0;
                if (sc == 1 && t == 5) begin ld = 1; val[0] = 6; val[1] = 1; end
                else if (sc >= 2 && $urandom_range(0, 7) == 0) begin
                    ld = 1; val[0] = $urandom_range(0, 9); val[1] = $urandom_range(0, 9);
                end
                if (ld) set_ratio(val[0], val[1]);
                div_load = ld;
                step();
                div_load = 1'b0;
                for (int k = 0; k < NUM_CH; k++) begin
                    if (r_cur[k] <= 1) begin
                        exp_ce[k] = 1;
                        if (ld) begin r_cur[k] = val[k]; nxt[k] = t + val[k]; pv[k] = 0; end
                    end else if (t == nxt[k]) begin
                        exp_ce[k] = 1;
                        if (ld) r_cur[k] = val[k];
                        else if (pv[k]) r_cur[k] = pnd[k];
                        pv[k] = 0;
                        nxt[k] = t + r_cur[k];
                    end else begin
                        exp_ce[k] = 0;
                        if (ld) begin pnd[k] = val[k]; pv[k] = 1; end
                    end
                end
                if (ce_out[0] === 1'b1) strobes.push_back(t);
                checks++;
                if (ce_out !== exp_ce) begin
                    errors++;
                    $display("FAIL div_ce sc%0d t=%0d: ce=%b want %b", sc, t, ce_out, exp_ce);
                end
            end
            if (sc == 1) begin
                checks++;
                if (strobes.size() != 4 || strobes[0] != 4 || strobes[1] != 8 ||
                    strobes[2] != 14 || strobes[3] != 20) begin
                    errors++;
                    $display("FAIL div_reload_times: got %0d strobes (%p), want 4 8 14 20",
                             strobes.size(), strobes);
                end
            end
        end
    endtask

    task automatic test_lock_loss();
        int e;
        int exp_cnt = 0;
        hard_reset();
        load_ratios(1, 1);
        bring_up(e);
        for (int n = 1; n <= 5; n++) begin
            step(); step();
            checks++;
            if (ce_out !== 2'b11) begin
                errors++;
                $display("FAIL loss_run_ce #%0d: ce=%b want 11", n, ce_out);
            end
            pll_locked = 1'b0;
            step(); step();
            checks++;
            if (rst_out_n !== 1'b1) begin
                errors++;
                $display("FAIL loss_hold #%0d: rst_out_n=%b want 1 two edges after drop", n, rst_out_n);
            end
            step();
            exp_cnt = (exp_cnt < 3) ? exp_cnt + 1 : 3;
            checks++;
            if (rst_out_n !== 1'b0 || locked !== 1'b0 || ce_out !== '0) begin
                errors++;
                $display("FAIL loss_drop #%0d: rst_out_n=%b locked=%b ce=%b want 0 0 00",
                         n, rst_out_n, locked, ce_out);
            end
            checks++;
            if (lock_loss_count !== CNT_W'(exp_cnt)) begin
                errors++;
                $display("FAIL loss_count #%0d: got %0d want %0d", n, lock_loss_count, exp_cnt);
            end
            step(); step();
            checks++;
            if (ce_out !== '0) begin
                errors++;
                $display("FAIL loss_ce_idle #%0d: ce=%b want 00", n, ce_out);
            end
            bring_up(e);
            checks++;
            if (e !== LAT) begin
                errors++;
                $display("FAIL loss_relock #%0d: locked at edge %0d want %0d", n, e, LAT);
            end
        end
    endtask

    task automatic test_clear();
        int e;
        lock_loss_clear = 1'b1;
        step();
        lock_loss_clear = 1'b0;
        checks++;
        if (lock_loss_count !== '0) begin
            errors++;
            $display("FAIL clear_plain: got %0d want 0", lock_loss_count);
        end
        pll_locked = 1'b0;
        step(); step();
        lock_loss_clear = 1'b1;
        step();
        lock_loss_clear = 1'b0;
        checks++;
        if (lock_loss_count !== CNT_W'(1)) begin
            errors++;
            $display("FAIL clear_collision: got %0d want 1", lock_loss_count);
        end
        step();
        bring_up(e);
    endtask

    task automatic test_async_reset();
        checks++;
        if (locked !== 1'b1 || ce_out !== 2'b11) begin
            errors++;
            $display("FAIL async_pre: locked=%b ce=%b want 1 11", locked, ce_out);
        end
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({rst_out_n, locked, ce_out, lock_loss_count} !== '0) begin
            errors++;
            $display("FAIL async_reset: rst_out_n=%b locked=%b ce=%b cnt=%0d want all 0",
                     rst_out_n, locked, ce_out, lock_loss_count);
        end
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_lock_latency();
        test_glitch();
        test_dividers();
        test_lock_loss();
        test_clear();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
